// File: rtl/btb_update_ctrl.sv
// BTB storage owner: 8-set x 2-way array plus LRU, EX update queue and a
// read-modify-write sequencer with a whole-table flush walk.
module btb_update_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   if_index,
  output logic [127:0] if_read_set,
  output logic [7:0]   if_lru,
  input  logic         if_lru_we,
  input  logic         if_next_lru,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [31:0]  upd_pc,
  input  logic [31:0]  upd_target,
  input  logic         upd_taken,
  input  logic         flush,
  output logic         busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [127:0] r_arr [8];
  logic [7:0]   r_lru;
  logic [31:2]  r_q_pc  [2];
  logic [31:0]  r_q_tgt [2];
  logic [1:0]   r_q_tk;
  logic         r_wp, r_rp;
  logic [1:0]   r_qn;
  logic [1:0]   r_st;
  logic [2:0]   r_fcnt;
  logic [31:2]  r_w_pc;
  logic [31:0]  r_w_tgt;
  logic         r_w_tk;
  logic [127:0] r_w_set;
  logic         r_w_lru;

  logic         w_empty, w_push, w_pop, w_unused;
  logic [2:0]   w_idx;
  logic [26:0]  w_tag;
  logic [63:0]  w_way1, w_way2;
  logic         w_hit1, w_hit2, w_vic2, w_wr_en, w_new_lru;
  logic [127:0] w_new_set;

  assign w_unused    = ^upd_pc[1:0];
  assign if_read_set = r_arr[if_index];
  assign if_lru      = r_lru;
  assign w_empty     = (r_qn == 2'd0);
  assign upd_ready   = (r_qn != 2'd2) && (r_st != S_FLUSH);
  assign busy        = (r_st != S_IDLE) || !w_empty;
  assign w_push      = upd_valid && upd_ready && !flush;
  assign w_pop       = !flush && !w_empty && ((r_st == S_IDLE) || (r_st == S_WR));

  assign w_idx  = r_w_pc[4:2];
  assign w_tag  = r_w_pc[31:5];
  assign w_way1 = r_w_set[127:64];
  assign w_way2 = r_w_set[63:0];
  assign w_hit1 = w_way1[63] && (w_way1[62:36] == w_tag);
  assign w_hit2 = !w_hit1 && w_way2[63] && (w_way2[62:36] == w_tag);
  // Replace way2 only when way1 is valid and either way2 is free or way1 is MRU.
  assign w_vic2 = w_way1[63] && (!w_way2[63] || !r_w_lru);

  function automatic logic [1:0] f_step(input logic [1:0] st, input logic tk);
    case (st)
      2'b00:   f_step = tk ? 2'b01 : 2'b00;
      2'b01:   f_step = tk ? 2'b11 : 2'b00;
      2'b11:   f_step = tk ? 2'b10 : 2'b01;
      default: f_step = tk ? 2'b10 : 2'b11;
    endcase
  endfunction

  function automatic logic [63:0] f_way(input logic [26:0] tag, input logic [31:0] tgt,
                                        input logic [1:0] st);
    f_way = {1'b1, tag, tgt, st, 2'b00};
  endfunction

  always_comb begin
    w_new_set = r_w_set;
    w_new_lru = r_w_lru;
    w_wr_en   = 1'b0;
    if (w_hit1) begin
      w_new_set[127:64] = f_way(w_tag, r_w_tgt, f_step(w_way1[3:2], r_w_tk));
      w_new_lru = 1'b0;
      w_wr_en   = 1'b1;
    end else if (w_hit2) begin
      w_new_set[63:0] = f_way(w_tag, r_w_tgt, f_step(w_way2[3:2], r_w_tk));
      w_new_lru = 1'b1;
      w_wr_en   = 1'b1;
    end else if (r_w_tk) begin
      if (w_vic2) w_new_set[63:0]   = f_way(w_tag, r_w_tgt, 2'b11);
      else        w_new_set[127:64] = f_way(w_tag, r_w_tgt, 2'b11);
      w_new_lru = w_vic2;
      w_wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_arr[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        r_q_pc[i]  <= '0;
        r_q_tgt[i] <= '0;
      end
      r_lru   <= '0;
      r_q_tk  <= '0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_qn    <= '0;
      r_st    <= S_IDLE;
      r_fcnt  <= '0;
      r_w_pc  <= '0;
      r_w_tgt <= '0;
      r_w_tk  <= 1'b0;
      r_w_set <= '0;
      r_w_lru <= 1'b0;
    end else begin
      // Later writes override earlier ones, so the WR update wins an LRU collision.
      if (r_st != S_FLUSH && if_lru_we) r_lru[if_index] <= if_next_lru;
      if (r_st == S_FLUSH) begin
        r_arr[r_fcnt] <= '0;
        r_lru[r_fcnt] <= 1'b0;
      end
      if (r_st == S_WR && !flush && w_wr_en) begin
        r_arr[w_idx] <= w_new_set;
        r_lru[w_idx] <= w_new_lru;
      end

      if (flush) begin
        r_qn <= '0;
        r_wp <= 1'b0;
        r_rp <= 1'b0;
      end else begin
        if (w_push) begin
          r_q_pc[r_wp]  <= upd_pc[31:2];
          r_q_tgt[r_wp] <= upd_target;
          r_q_tk[r_wp]  <= upd_taken;
          r_wp          <= ~r_wp;
        end
        if (w_pop) begin
          r_w_pc  <= r_q_pc[r_rp];
          r_w_tgt <= r_q_tgt[r_rp];
          r_w_tk  <= r_q_tk[r_rp];
          r_rp    <= ~r_rp;
        end
        case ({w_push, w_pop})
          2'b10:   r_qn <= r_qn + 2'd1;
          2'b01:   r_qn <= r_qn - 2'd1;
          default: r_qn <= r_qn;
        endcase
      end

      if (flush) begin
        r_st   <= S_FLUSH;
        r_fcnt <= '0;
      end else begin
        case (r_st)
          S_IDLE: if (!w_empty) r_st <= S_RD;
          S_RD: begin
            r_w_set <= r_arr[w_idx];
            r_w_lru <= r_lru[w_idx];
            r_st    <= S_WR;
          end
          S_WR:    r_st <= w_empty ? S_IDLE : S_RD;
          default: begin
            if (r_fcnt == 3'd7) r_st <= S_IDLE;
            r_fcnt <= r_fcnt + 3'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: way-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_btb_update_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   if_index;
  logic [127:0] if_read_set;
  logic [7:0]   if_lru;
  logic         if_lru_we, if_next_lru;
  logic         upd_valid, upd_ready;
  logic [31:0]  upd_pc, upd_target;
  logic         upd_taken, flush, busy;

  int checks = 0;
  int errors = 0;

  btb_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_index(if_index), .if_read_set(if_read_set),
    .if_lru(if_lru), .if_lru_we(if_lru_we), .if_next_lru(if_next_lru),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] tgt; logic tk; } upd_t;
  upd_t        mq[$];
  upd_t        cur;
  logic        mv   [8][2];
  logic [26:0] mtag [8][2];
  logic [31:0] mtgt [8][2];
  logic [1:0]  mst  [8][2];
  logic [7:0]  mlru;
  logic        sv   [2];
  logic [26:0] stag [2];
  logic [31:0] stgt [2];
  logic [1:0]  sst  [2];
  logic        slru;
  int          mph;   // 0 none in flight, 1 reading set, 2 writing set
  bit          mfl;
  int          mfc;

  // Predictor as a saturating strength level: SNT < WNT < WT < ST.
  function automatic int lvl(input logic [1:0] s);
    case (s) 2'b00: return 0; 2'b01: return 1; 2'b11: return 2; default: return 3; endcase
  endfunction
  function automatic logic [1:0] enc(input int l);
    case (l) 0: return 2'b00; 1: return 2'b01; 2: return 2'b11; default: return 2'b10; endcase
  endfunction

  task automatic clear_set(input int s);
    for (int w = 0; w < 2; w++) begin
      mv[s][w] = 1'b0; mtag[s][w] = '0; mtgt[s][w] = '0; mst[s][w] = '0;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) clear_set(s);
    mlru = '0; mq.delete(); mph = 0; mfl = 0; mfc = 0;
  endtask

  task automatic apply_upd();
    int idx, hw, vic, l;
    logic [26:0] tag;
    idx = int'(cur.pc[4:2]);
    tag = cur.pc[31:5];
    hw  = -1;
    for (int w = 1; w >= 0; w--) if (sv[w] && stag[w] == tag) hw = w;
    if (hw >= 0) begin
      l = lvl(sst[hw]);
      l = cur.tk ? ((l < 3) ? l + 1 : 3) : ((l > 0) ? l - 1 : 0);
      stgt[hw] = cur.tgt; sst[hw] = enc(l);
      mlru[idx] = (hw == 1);
    end else if (cur.tk) begin
      vic = !sv[0] ? 0 : (!sv[1] ? 1 : (slru ? 0 : 1));
      sv[vic] = 1'b1; stag[vic] = tag; stgt[vic] = cur.tgt; sst[vic] = 2'b11;
      mlru[idx] = (vic == 1);
    end else return;
    for (int w = 0; w < 2; w++) begin
      mv[idx][w] = sv[w]; mtag[idx][w] = stag[w]; mtgt[idx][w] = stgt[w]; mst[idx][w] = sst[w];
    end
  endtask

  task automatic mstep();
    bit fl0, rdy;
    int ph0, idx;
    fl0 = mfl; ph0 = mph;
    rdy = (mq.size() < 2) && !fl0;
    if (!fl0 && ph0 == 1 && !flush) begin
      idx = int'(cur.pc[4:2]);
      for (int w = 0; w < 2; w++) begin
        sv[w] = mv[idx][w]; stag[w] = mtag[idx][w]; stgt[w] = mtgt[idx][w]; sst[w] = mst[idx][w];
      end
      slru = mlru[idx];
    end
    if (!fl0 && if_lru_we) mlru[if_index] = if_next_lru;
    if (fl0) begin clear_set(mfc); mlru[mfc] = 1'b0; end
    if (flush) begin
      mq.delete(); mph = 0; mfl = 1; mfc = 0;
    end else if (fl0) begin
      if (mfc == 7) mfl = 0;
      mfc = (mfc + 1) % 8;
    end else begin
      if (ph0 == 2) apply_upd();
      if (ph0 == 1) mph = 2;
      else if (mq.size() > 0) begin cur = mq.pop_front(); mph = 1; end
      else mph = 0;
      if (upd_valid && rdy) mq.push_back('{pc: upd_pc, tgt: upd_target, tk: upd_taken});
    end
  endtask

  function automatic logic [63:0] mway(input int s, input int w);
    return {mv[s][w], mtag[s][w], mtgt[s][w], mst[s][w], 2'b00};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) mstep(); else model_reset();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [127:0] es;
    logic         er, eb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        es = {mway(int'(if_index), 0), mway(int'(if_index), 1)};
        er = (mq.size() < 2) && !mfl;
        eb = mfl || (mph != 0) || (mq.size() > 0);
        checks += 4;
        if (if_read_set !== es) begin
          errors++; $display("FAIL model_set idx=%0d got %h want %h", if_index, if_read_set, es);
        end
        if (if_lru !== mlru) begin
          errors++; $display("FAIL model_lru got %h want %h", if_lru, mlru);
        end
        if (upd_ready !== er) begin
          errors++; $display("FAIL model_ready got %b want %b t=%0t", upd_ready, er, $time);
        end
        if (busy !== eb) begin
          errors++; $display("FAIL model_busy got %b want %b t=%0t", busy, eb, $time);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [63:0] W(input logic [26:0] tag, input logic [31:0] tgt,
                                    input logic [1:0] st);
    return {1'b1, tag, tgt, st, 2'b00};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic view(input logic [2:0] i, input string nm, input logic [127:0] exp);
    if_index = i; #1;
    chk(nm, if_read_set, exp);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_valid = 1'b1;
    cyc(1);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin cyc(1); n++; end
    checks++;
    if (busy) begin errors++; $display("FAIL idle_timeout got busy=%b want 0", busy); end
  endtask

  initial begin
    logic [1:0] nt_st [3];
    nt_st = '{2'b01, 2'b00, 2'b00};
    rst_n = 1'b0; if_index = '0; if_lru_we = 1'b0; if_next_lru = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) view(3'(i), "rst_set", '0);
    chk("rst_lru", 128'(if_lru), 128'h0);
    chk("rst_ready", 128'(upd_ready), 128'h1);
    chk("rst_busy", 128'(busy), 128'h0);

    // First allocation, latency to IF visibility.
    push1(32'h0000_0104, 32'h0000_0200, 1'b1);
    cyc(2);
    view(3'd1, "alloc_early", '0);
    cyc(1);
    view(3'd1, "alloc", {W(27'd8, 32'h200, 2'b11), 64'd0});
    chk("alloc_lru", 128'(if_lru), 128'h00);
    chk("alloc_busy", 128'(busy), 128'h0);

    // Not-taken hits walk the predictor down and rewrite the target.
    for (int k = 0; k < 3; k++) begin
      push1(32'h0000_0104, 32'h300 + 32'(4 * k), 1'b0);
      cyc(3);
      view(3'd1, "nt_step", {W(27'd8, 32'h300 + 32'(4 * k), nt_st[k]), 64'd0});
    end

    // Fill set 1 and exercise victim choice.
    push1(32'h0000_0024, 32'h400, 1'b1); cyc(3);
    view(3'd1, "fill_w2", {W(27'd8, 32'h308, 2'b00), W(27'd1, 32'h400, 2'b11)});
    chk("fill_lru", 128'(if_lru), 128'h02);
    push1(32'h0000_0104, 32'h500, 1'b1); cyc(3);
    view(3'd1, "hit_w1", {W(27'd8, 32'h500, 2'b01), W(27'd1, 32'h400, 2'b11)});
    chk("hit_lru", 128'(if_lru), 128'h00);
    push1(32'h0000_0044, 32'h600, 1'b1); cyc(3);
    view(3'd1, "vic_w2", {W(27'd8, 32'h500, 2'b01), W(27'd2, 32'h600, 2'b11)});
    chk("vic_w2_lru", 128'(if_lru), 128'h02);
    push1(32'h0000_0064, 32'h700, 1'b1); cyc(3);
    view(3'd1, "vic_w1", {W(27'd3, 32'h700, 2'b11), W(27'd2, 32'h600, 2'b11)});
    chk("vic_w1_lru", 128'(if_lru), 128'h00);
    push1(32'h0000_0084, 32'h800, 1'b0); cyc(3);
    view(3'd1, "nt_miss", {W(27'd3, 32'h700, 2'b11), W(27'd2, 32'h600, 2'b11)});

    // IF-side LRU write.
    if_index = 3'd5; if_lru_we = 1'b1; if_next_lru = 1'b1;
    cyc(1);
    if_lru_we = 1'b0;
    chk("if_lru_we", 128'(if_lru), 128'h20);

    // Three consecutive pushes fill the queue; applied in order.
    upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h900; upd_taken = 1'b1; cyc(1);
    upd_pc = 32'h10C; upd_target = 32'hA00; cyc(1);
    upd_pc = 32'h108; upd_target = 32'hB00; upd_taken = 1'b0; cyc(1);
    upd_valid = 1'b0;
    chk("q_full_ready", 128'(upd_ready), 128'h0);
    wait_idle(40);
    view(3'd2, "seq_set2", {W(27'd8, 32'hB00, 2'b01), 64'd0});
    view(3'd3, "seq_set3", {W(27'd8, 32'hA00, 2'b11), 64'd0});
    chk("seq_lru", 128'(if_lru), 128'h20);

    // LRU collisions during WR: same index (WR wins), different index (both).
    push1(32'h108, 32'hD00, 1'b1); cyc(2);
    if_index = 3'd2; if_lru_we = 1'b1; if_next_lru = 1'b1; cyc(1);
    if_lru_we = 1'b0;
    chk("wr_wins_lru", 128'(if_lru), 128'h20);
    view(3'd2, "wr_wins_set", {W(27'd8, 32'hD00, 2'b11), 64'd0});
    push1(32'h108, 32'hE00, 1'b1); cyc(2);
    if_index = 3'd6; if_lru_we = 1'b1; if_next_lru = 1'b1; cyc(1);
    if_lru_we = 1'b0;
    chk("both_lru", 128'(if_lru), 128'h60);
    view(3'd2, "both_set", {W(27'd8, 32'hE00, 2'b10), 64'd0});

    // Flush during RD with one entry queued and a same-cycle push.
    upd_valid = 1'b1; upd_pc = 32'h10C; upd_target = 32'hC00; upd_taken = 1'b1; cyc(1);
    upd_target = 32'hF00; cyc(1);
    upd_pc = 32'h110; upd_target = 32'h111; flush = 1'b1; cyc(1);
    upd_valid = 1'b0; flush = 1'b0;
    chk("fl_ready", 128'(upd_ready), 128'h0);
    chk("fl_busy", 128'(busy), 128'h1);
    view(3'd3, "fl_no_write", {W(27'd8, 32'hA00, 2'b11), 64'd0});
    cyc(7);
    chk("fl_last_ready", 128'(upd_ready), 128'h0);
    chk("fl_last_busy", 128'(busy), 128'h1);
    cyc(1);
    chk("fl_done_ready", 128'(upd_ready), 128'h1);
    chk("fl_done_busy", 128'(busy), 128'h0);
    chk("fl_done_lru", 128'(if_lru), 128'h0);
    for (int i = 0; i < 8; i++) view(3'(i), "fl_set", '0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
